// File: rtl/manchester_pkg.sv
`timescale 1ns/1ps
// Shared state type and timing thresholds for the Manchester receive path.
// Thresholds are expressed in clk cycles as functions of the half-bit length.
package manchester_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic IDLE_LEVEL = 1'b0;

    function automatic int glitch_max(input int h);
        return h / 2;
    endfunction

    function automatic int mid_min(input int h);
        return (3 * h) / 2;
    endfunction

    function automatic int mid_max(input int h);
        return (5 * h) / 2;
    endfunction

    function automatic int arm_cycles(input int h);
        return 2 * h;
    endfunction

endpackage

// File: rtl/manchester_rx_sync.sv
`timescale 1ns/1ps
// Two-flop synchroniser for the asynchronous line plus a history flop,
// giving the clean level and single-cycle edge strobes.
module manchester_rx_sync
    import manchester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_line,
    output logic o_s2,
    output logic o_edge,
    output logic o_rising
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= IDLE_LEVEL;
            r_s2 <= IDLE_LEVEL;
            r_s3 <= IDLE_LEVEL;
        end else if (i_clr) begin
            r_s1 <= IDLE_LEVEL;
            r_s2 <= IDLE_LEVEL;
            r_s3 <= IDLE_LEVEL;
        end else begin
            r_s1 <= i_line;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_s2     = r_s2;
    assign o_edge   = r_s2 ^ r_s3;
    assign o_rising = r_s2 & ~r_s3;

endmodule

// File: rtl/manchester_decoder.sv
`timescale 1ns/1ps
// Manchester (IEEE 802.3) receiver: arms after a quiet low line, locks on the
// start-bit mid edge, then samples each mid-bit transition into a shift register.
module manchester_decoder
    import manchester_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 4,
    parameter int DATA_BITS       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 line_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int H       = HALF_BIT_CYCLES;
    localparam int CNT_SAT = 3 * H;
    localparam int CW      = $clog2(CNT_SAT + 1);
    localparam int IW      = $clog2(arm_cycles(H) + 1);
    localparam int BW      = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] GLITCH_MAX = CW'(glitch_max(H));
    localparam logic [CW-1:0] MID_MIN    = CW'(mid_min(H));
    localparam logic [CW-1:0] MID_MAX    = CW'(mid_max(H));
    localparam logic [CW-1:0] CNT_MAX    = CW'(CNT_SAT);
    localparam logic [IW-1:0] ARM_CYCLES = IW'(arm_cycles(H));
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

    logic w_s2;
    logic w_edge;
    logic w_rising;

    state_t               r_state, w_state_nx;
    logic [CW-1:0]        r_cnt, w_cnt_nx;
    logic [IW-1:0]        r_idle_cnt, w_idle_nx;
    logic                 r_armed, w_armed_nx;
    logic [BW-1:0]        r_bit_cnt, w_bit_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_err;
    logic                 w_done;
    logic                 w_err;
    logic                 w_rearm;

    manchester_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!enable),
        .i_line   (line_in),
        .o_s2     (w_s2),
        .o_edge   (w_edge),
        .o_rising (w_rising)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        w_bit_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_rearm    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rising && r_armed) begin
                    w_state_nx = DATA;
                    w_cnt_nx   = '0;
                    w_bit_nx   = '0;
                    w_rearm    = 1'b1;
                end
            end
            DATA: begin
                if (w_edge && r_cnt >= MID_MIN && r_cnt <= MID_MAX) begin
                    w_shift_nx = {r_shift[DATA_BITS-2:0], w_s2};
                    w_cnt_nx   = '0;
                    w_bit_nx   = r_bit_cnt + 1'b1;
                    w_done     = (r_bit_cnt == LAST_BIT);
                end else if ((w_edge && r_cnt < GLITCH_MAX) || r_cnt > MID_MAX) begin
                    w_err = 1'b1;
                end
                if (w_done || w_err) begin
                    w_state_nx = IDLE;
                    w_rearm    = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase

        // The quiet-time count restarts from the cycle a frame ends, so the
        // low cycle that carried a final falling edge already counts.
        if (w_rearm)
            w_idle_nx = (w_s2 == IDLE_LEVEL) ? IW'(1) : '0;
        else if (w_s2 != IDLE_LEVEL)
            w_idle_nx = '0;
        else if (r_idle_cnt == ARM_CYCLES)
            w_idle_nx = r_idle_cnt;
        else
            w_idle_nx = r_idle_cnt + 1'b1;
        w_armed_nx = !w_rearm && (r_armed || (w_idle_nx == ARM_CYCLES));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idle_cnt <= '0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else if (!enable) begin
            // A violation detected in the cycle enable falls is still reported.
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idle_cnt <= '0;
            r_armed    <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_valid    <= 1'b0;
            r_err      <= w_err;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_idle_cnt <= w_idle_nx;
            r_armed    <= w_armed_nx;
            r_bit_cnt  <= w_bit_nx;
            r_shift    <= w_shift_nx;
            r_valid    <= w_done;
            r_err      <= w_err;
            if (w_done)
                r_data <= w_shift_nx;
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_err;
    assign busy       = (r_state == DATA);

endmodule

// File: tb/tb_manchester_decoder.sv
`timescale 1ns/1ps
// Directed bench for manchester_decoder (H=4, 8 data bits): a table of whole
// frames followed by hand-written error, reset and enable sequences.
module tb_manchester_decoder;

    localparam int H  = 4;
    localparam int DB = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          enable  = 1'b1;
    logic          line_in = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    manchester_decoder #(.HALF_BIT_CYCLES(H), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .line_in    (line_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   n_tests  = 0;
    int   n_fail   = 0;
    int   v_cnt    = 0;
    int   e_cnt    = 0;
    int   long_cnt = 0;
    logic prev_v   = 1'b0;
    logic prev_e   = 1'b0;

    // Pulse monitor: counts strobes and any strobe lasting more than one cycle.
    always @(negedge clk) begin
        if (data_valid) v_cnt <= v_cnt + 1;
        if (frame_err)  e_cnt <= e_cnt + 1;
        if ((data_valid && prev_v) || (frame_err && prev_e)) long_cnt <= long_cnt + 1;
        prev_v <= data_valid;
        prev_e <= frame_err;
    end

    typedef struct {
        logic [7:0] data;
        int         pre;
        int         exp_v;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            line_in = v;
        end
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b0, H);
            drive(1'b1, H);
        end else begin
            drive(1'b1, H);
            drive(1'b0, H);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // pre = low cycles driven right before the start-bit mid-edge rise.
    task automatic send_frame(input logic [7:0] d, input int pre);
        drive(1'b0, pre);
        drive(1'b1, H);
        for (int i = DB - 1; i >= 0; i--) send_bit(d[i]);
        settle();
    endtask

    initial begin
        int v0;
        int e0;

        // After 0x00 the line is already low for H cycles, so pre=4 gives a
        // low run of exactly 8 and pre=3 a run of 7.
        vecs[0] = '{8'hA5, 14, 1, 8'hA5};
        vecs[1] = '{8'h00, 12, 1, 8'h00};
        vecs[2] = '{8'hFF,  4, 1, 8'hFF};
        vecs[3] = '{8'h00, 12, 1, 8'h00};
        vecs[4] = '{8'hFF,  3, 0, 8'h00};
        vecs[5] = '{8'h3C, 12, 1, 8'h3C};
        vecs[6] = '{8'h81,  8, 1, 8'h81};

        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            v0 = v_cnt;
            e0 = e_cnt;
            send_frame(vecs[k].data, vecs[k].pre);
            chk($sformatf("vec%0d_valid_pulses", k), v_cnt - v0, vecs[k].exp_v);
            chk($sformatf("vec%0d_err_pulses", k), e_cnt - e0, 0);
            chk($sformatf("vec%0d_data_out", k), data_out, vecs[k].exp_d);
            chk($sformatf("vec%0d_busy_after", k), busy, 0);
        end

        // Missing transition: line held high after the 3rd data bit.
        v0 = v_cnt;
        e0 = e_cnt;
        drive(1'b0, 12);
        drive(1'b1, H);
        send_bit(1'b1);
        send_bit(1'b0);
        #1;
        chk("miss_busy_mid", busy, 1);
        send_bit(1'b1);
        drive(1'b1, 12);
        settle();
        chk("miss_err_pulses", e_cnt - e0, 1);
        chk("miss_valid_pulses", v_cnt - v0, 0);
        chk("miss_data_kept", data_out, 8'h81);
        chk("miss_busy_after", busy, 0);

        // One-cycle glitch right after the first data bit's mid edge.
        v0 = v_cnt;
        e0 = e_cnt;
        drive(1'b0, 12);
        drive(1'b1, H);
        drive(1'b0, H);
        drive(1'b1, 1);
        drive(1'b0, 1);
        drive(1'b1, 6);
        drive(1'b0, 12);
        settle();
        chk("glitch_err_pulses", e_cnt - e0, 1);
        chk("glitch_valid_pulses", v_cnt - v0, 0);
        chk("glitch_data_kept", data_out, 8'h81);
        chk("glitch_busy_after", busy, 0);
        send_frame(8'h3C, 12);
        chk("post_glitch_valid", v_cnt - v0, 1);
        chk("post_glitch_data", data_out, 8'h3C);

        // Reset in the middle of a 0x5A frame.
        v0 = v_cnt;
        e0 = e_cnt;
        drive(1'b0, 12);
        drive(1'b1, H);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        rst_n   = 1'b0;
        line_in = 1'b0;
        #1;
        chk("midrst_data_out", data_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_err", frame_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_frame(8'h5A, 12);
        chk("post_rst_valid", v_cnt - v0, 1);
        chk("post_rst_err", e_cnt - e0, 0);
        chk("post_rst_data", data_out, 8'h5A);

        // Enable dropped for one cycle in the middle of a 0xFF frame.
        v0 = v_cnt;
        e0 = e_cnt;
        fork
            send_frame(8'hFF, 12);
            begin
                repeat (40) @(negedge clk);
                enable = 1'b0;
                @(negedge clk);
                enable = 1'b1;
            end
        join
        chk("en_drop_valid", v_cnt - v0, 0);
        chk("en_drop_err", e_cnt - e0, 0);
        chk("en_drop_data_kept", data_out, 8'h5A);
        chk("en_drop_busy", busy, 0);
        send_frame(8'h81, 12);
        chk("post_en_valid", v_cnt - v0, 1);
        chk("post_en_data", data_out, 8'h81);

        repeat (4) @(negedge clk);
        chk("single_cycle_pulses", long_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
